// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: LSB-first bit stream qualified by dout_en.
// Optional trailing parity bit when SERIAL_PARITY_EN is defined.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("piso_serializer: WIDTH must be >= 2");
  end
  if (ODD_PARITY > 1'b1) begin : g_bad_parity
    $error("piso_serializer: ODD_PARITY must be 0 or 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             dout_q;
  logic             dout_en_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_PARITY_EN
  logic             par_q;
`endif

  always_comb begin
    count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      count_q   <= '0;
      dout_q    <= 1'b0;
      dout_en_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid && ready_q) begin
            shreg_q   <= load_data >> 1;
            dout_q    <= load_data[0];
            dout_en_q <= 1'b1;
            count_q   <= CW'(1);
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef SERIAL_PARITY_EN
            par_q     <= (^load_data) ^ ODD_PARITY;
`endif
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q < LAST) begin
            dout_q  <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            count_q <= count_d;
          end
`ifdef SERIAL_PARITY_EN
          // count == WIDTH here means data is exhausted; emit parity before closing.
          else if (count_q == LAST) begin
            dout_q  <= par_q;
            count_q <= count_d;
          end
`endif
          else begin
            dout_q    <= 1'b0;
            dout_en_q <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = ready_q;
  assign dout       = dout_q;
  assign dout_en    = dout_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus pushes hand-written bit streams,
// a negedge monitor pops and compares whenever dout_en or done is presented.
module tb_piso_serializer;

  localparam int  WIDTH = 8;
  localparam bit  ODD   = 1'b0;
`ifdef SERIAL_PARITY_EN
  localparam int  PBIT  = 1;
`else
  localparam int  PBIT  = 0;
`endif
  localparam int  FLEN  = WIDTH + PBIT + 1;
  localparam bit  RX_LAST = (PBIT != 0) ? 1'b0 : 1'b1;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             dout;
  logic             dout_en;
  logic             busy;
  logic             done;
  logic             rx_q = 1'b0;

  typedef struct packed {
    bit is_done;
    bit val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  piso_serializer #(.WIDTH(WIDTH), .ODD_PARITY(ODD)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .dout      (dout),
    .dout_en   (dout_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dout_en) rx_q <= dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // seq is written in transmission order; par is the even parity of the word.
  task automatic push_frame(input bit [0:WIDTH-1] seq, input bit par);
    for (int i = 0; i < WIDTH; i++) sb.push_back('{is_done: 1'b0, val: seq[i]});
    if (PBIT != 0) sb.push_back('{is_done: 1'b0, val: par ^ ODD});
    sb.push_back('{is_done: 1'b1, val: 1'b0});
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_outs", {dout, dout_en, load_ready, busy, done}, 5'b00100);
    end else begin
      if (dout_en) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_bit: dout_en=1 dout=%0b with nothing expected", dout);
        end else begin
          e = sb.pop_front();
          if (e.is_done) begin
            checks++;
            $display("FAIL bit_vs_done: got bit %0b expected done pulse", dout);
          end else begin
            check("dout", dout, e.val);
          end
          check("shift_hs", {load_ready, busy, done}, 3'b010);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 with nothing expected");
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            checks++;
            $display("FAIL done_vs_bit: got done expected bit %0b", e.val);
          end else begin
            check("done_outs", {load_ready, dout_en, busy}, 3'b100);
          end
        end
      end
      if (load_ready) check("idle_outs", {dout, dout_en, busy}, 3'b000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    reset      = 1'b0;
    load_valid = 1'b0;

    // idle with no valid for 50 cycles
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (busy || done || dout_en || !load_ready) bad = 1'b1;
    end
    check("idle50", bad, 0);

    // single frame A5
    @(posedge clk); #1;
    push_frame('b10100101, 1'b0);
    load_data  = 8'hA5;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 8'hFF;
    check("first_bit_latency", {dout_en, dout, busy, load_ready}, 4'b1110);
    wait_drain(30);

    // held valid: 3C then 81, exactly one idle cycle between frames
    @(posedge clk); #1;
    push_frame('b00111100, 1'b0);
    push_frame('b10000001, 1'b0);
    load_data  = 8'h3C;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_data  = 8'h81;
    repeat (FLEN - 1) @(posedge clk);
    #1;
    check("gap_cycle", {dout_en, load_ready, done, busy}, 4'b0110);
    @(posedge clk); #1;
    check("second_accept", {dout_en, dout, busy, load_ready}, 4'b1110);
    load_valid = 1'b0;
    wait_drain(30);
    check("rx_register", rx_q, RX_LAST);

    // reset mid-frame after the 4th bit, then reload 01
    @(posedge clk); #1;
    push_frame('b00001111, 1'b0);
    load_data  = 8'hF0;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("bits_before_reset", sb.size(), 5 + PBIT);
    reset = 1'b1;
    #1;
    check("async_reset", {dout_en, busy, done, load_ready}, 4'b0001);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    push_frame('b10000000, 1'b1);
    load_data  = 8'h01;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_drain(30);

    // 07: check frame-end edge position (parity bit present when enabled)
    @(posedge clk); #1;
    push_frame('b11100000, 1'b1);
    load_data  = 8'h07;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (FLEN - 2) @(posedge clk);
    #1;
    check("last_bit_cycle", {dout_en, done}, 2'b10);
    @(posedge clk); #1;
    check("frame_end_cycle", {dout_en, done, load_ready}, 3'b011);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    wait_drain(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Produces the 1-bit data/enable stream that a downstream 1-bit enabled register (din/en) captures.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock.
- Each bit is qualified by dout_en, which connects directly to the receiving register's en input.

Parameters:
- WIDTH, 8, data word width in bits; must be >= 2.
- ODD_PARITY, 0, parity sense for the optional parity bit (0 = even, 1 = odd); ignored unless SERIAL_PARITY_EN is defined.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data holds a word to transmit.
- load_data  input  WIDTH  parallel word; sampled only when load_valid is high and load_ready is high.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data bit.
- dout_en  output  1  dout holds a valid bit this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final bit of a frame.

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is asynchronous and active-high.
  - Reset forces state IDLE, shift register 0, bit counter 0, dout=0, dout_en=0, load_ready=1, busy=0, done=0.
  - These values take effect immediately on reset assertion, without waiting for a clock edge.
- Outputs: all outputs are registered; there are no combinational paths from inputs to outputs.
- State machine:
  - Two states: IDLE and SHIFT.
  - Bit counter width is $clog2(WIDTH+2).
- IDLE:
  - load_ready=1, busy=0, dout_en=0, dout=0.
  - Accept edge E0 is a rising edge with load_valid=1 and load_ready=1. At E0:
    - shreg <= load_data >> 1
    - dout <= load_data[0], dout_en <= 1
    - count <= 1, load_ready <= 0, busy <= 1
    - state <= SHIFT
- SHIFT:
  - At each edge while count < WIDTH: dout <= shreg[0], shreg <= shreg >> 1, count <= count+1, dout_en stays 1.
  - Bit k (k = 0..WIDTH-1) is presented on dout, with dout_en=1, for exactly the one cycle following edge E0+k.
- Frame end (edge E0+WIDTH, no parity):
  - dout_en <= 0, dout <= 0, done <= 1, busy <= 0, load_ready <= 1, state <= IDLE.
  - done deasserts at the next edge.
- Throughput:
  - One word per WIDTH+1 cycles.
  - Earliest next accept edge is E0+WIDTH+1, so back-to-back frames are separated by exactly one cycle with dout_en=0.
- Boundary conditions:
  - load_valid while load_ready=0: ignored; load_data is not sampled; no handshake state is stored.
  - load_data changes during SHIFT: no effect on the frame in flight.
  - Reset mid-frame: partial word discarded; done does not pulse; the next accepted word transmits normally.
  - load_valid held high continuously: words are accepted at E0, then E0+WIDTH+1, and so on. The source must update load_data after each accept.
  - In IDLE, dout is always 0 and dout_en is always 0.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is emitted with dout_en=1 at edge E0+WIDTH.
  - Value: XOR reduction of the accepted word, XOR ODD_PARITY. The word is latched at E0.
  - Frame end (dout_en=0, done=1, load_ready=1) moves to edge E0+WIDTH+1.
  - Throughput becomes one word per WIDTH+2 cycles.
- Undefined: no parity bit, no parity storage logic, and ODD_PARITY has no effect.

Test Plan:
1. Reset with clk running, load_valid=1 → dout=0, dout_en=0, load_ready=1, busy=0, done=0 for the whole time reset is high. Reset asserted between clock edges → outputs clear immediately.
2. WIDTH=8, load 8'hA5 → dout=1,0,1,0,0,1,0,1 on 8 consecutive cycles with dout_en=1. Next cycle: dout_en=0, done=1 for one cycle, load_ready=1.
3. load_valid held high with 8'h3C, then 8'h81 presented after the first accept → second frame starts at E0+9. Serial streams are 0,0,1,1,1,1,0,0 and 1,0,0,0,0,0,0,1, separated by exactly one dout_en=0 cycle. A bench 1-bit register on (dout, dout_en) ends holding 1.
4. Load 8'hF0, assert reset after the 4th bit → dout_en drops immediately, no done pulse. Reload 8'h01 → stream 1,0,0,0,0,0,0,0, then done.
5. SERIAL_PARITY_EN defined, ODD_PARITY=0, load 8'h07 → 9th bit with dout_en=1 is 1, and done comes at E0+9. Same with ODD_PARITY=1 → 9th bit is 0.
6. load_valid=0 for 50 cycles after reset → dout_en, busy and done never assert; load_ready stays 1.
